// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Gate-time sequencer for the frequency meter. It opens a freq_en window of a
// programmable number of clk cycles and counts rising edges of sig_in inside
// that window. At the end of each window the count is latched into RESULT,
// DONE is set and an interrupt is raised to the Nios II if IRQ_EN is set.
// The block is an Avalon-MM slave with four 32-bit registers:
//   0 CTRL   : bit0 START (write 1 to start, reads BUSY), bit1 CONT,
//              bit2 IRQ_EN, bit3 STOP (write 1 to abort, reads 0)
//   1 GATE   : window length in clk cycles (0 behaves as 1)
//   2 RESULT : latched edge count (read-only)
//   3 STATUS : bit0 DONE, bit1 OVF, both sticky; any write clears them
//
// Parameters:
//   CNT_W    edge counter / result width (1..32)
//   GATE_RST reset value of the GATE register
//
// Ports:
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   irq         DONE & IRQ_EN
//   sig_in      measured signal
//   freq_en     measurement window, high while in the GATE state
//
// Build option:
//   FREQ_GATE_SYNC_EN  when defined, sig_in passes through a 2-FF
//                      synchronizer before edge detection (3-cycle latency).
//                      When undefined, sig_in must already be synchronous to
//                      clk and the edge is detected combinationally.
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] GATE_RST = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        sig_in,
  output logic        freq_en
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               freq_en_q, freq_en_d;
  logic               cont_q, cont_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        gate_q, gate_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_run_q, ovf_run_d;
  logic [31:0]        readdata_q, readdata_d;

  logic               edge_pulse;
  logic               wr_en;
  logic               ctrl_wr;
  logic               start_wr;
  logic               stop_wr;
  logic [31:0]        gate_load;

  // Edge detector on the measured signal.
`ifdef FREQ_GATE_SYNC_EN
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_pulse = s2_q & ~s3_q;
`else
  logic s3_q, s3_d;

  always_comb begin
    s3_d = sig_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_q <= 1'b0;
    end else begin
      s3_q <= s3_d;
    end
  end

  // sig_in is already clk-synchronous here, so the edge is seen in the same
  // cycle it occurs.
  assign edge_pulse = sig_in & ~s3_q;
`endif

  // Bus decode, register updates and the gate sequencer.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    ctrl_wr   = wr_en && (address == 2'd0);
    start_wr  = ctrl_wr & writedata[0];
    stop_wr   = ctrl_wr & writedata[3];
    gate_load = (gate_q == 32'd0) ? 32'd1 : gate_q;

    state_d    = state_q;
    cont_d     = cont_q;
    irq_en_d   = irq_en_q;
    gate_d     = gate_q;
    result_d   = result_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_run_d  = ovf_run_q;

    if (ctrl_wr) begin
      cont_d   = writedata[1];
      irq_en_d = writedata[2];
    end

    // A GATE write only takes effect at the next reload; the running window
    // keeps its own down-counter.
    if (wr_en && (address == 2'd1)) begin
      gate_d = writedata;
    end

    // Status clear comes first so that a LATCH set in the same cycle wins.
    if (wr_en && (address == 2'd3)) begin
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // START together with STOP leaves the sequencer idle.
        if (start_wr && !stop_wr) begin
          state_d    = ST_GATE;
          gate_cnt_d = gate_load;
          edge_cnt_d = '0;
          ovf_run_d  = 1'b0;
        end
      end

      ST_GATE: begin
        if (stop_wr) begin
          state_d = ST_IDLE;
        end else begin
          if (edge_pulse) begin
            if (&edge_cnt_q) begin
              ovf_run_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
          if (gate_cnt_q <= 32'd1) begin
            state_d = ST_LATCH;
          end else begin
            gate_cnt_d = gate_cnt_q - 32'd1;
          end
        end
      end

      ST_LATCH: begin
        if (stop_wr) begin
          state_d = ST_IDLE;
        end else begin
          result_d = 32'(edge_cnt_q);
          done_d   = 1'b1;
          ovf_d    = ovf_q | ovf_run_q;
          if (cont_q) begin
            state_d    = ST_GATE;
            gate_cnt_d = gate_load;
            edge_cnt_d = '0;
            ovf_run_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so freq_en tracks the GATE state exactly, without glitches.
    freq_en_d = (state_d == ST_GATE);

    case (address)
      2'd0:    readdata_d = {28'd0, 1'b0, irq_en_q, cont_q, (state_q != ST_IDLE)};
      2'd1:    readdata_d = gate_q;
      2'd2:    readdata_d = result_q;
      2'd3:    readdata_d = {30'd0, ovf_q, done_q};
      default: readdata_d = 32'd0;
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      freq_en_q  <= 1'b0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      gate_q     <= GATE_RST;
      result_q   <= 32'd0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      gate_cnt_q <= 32'd0;
      edge_cnt_q <= '0;
      ovf_run_q  <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      freq_en_q  <= freq_en_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      gate_q     <= gate_d;
      result_q   <= result_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_run_q  <= ovf_run_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign freq_en  = freq_en_q;
  assign irq      = done_q & irq_en_q;

endmodule
